// File: rtl/merlin_wb_arbiter.sv
// Writeback arbiter and destination-register scoreboard for the integer register file.
// Latency: a request accepted in cycle N drives its register-file write strobe in cycle N+1.
// Backpressure: up to two nonzero-destination requests are granted per cycle; the others see ready=0 and hold.
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        per-requester handshake (requester 0 = ALU)
//   req_addr_i/req_data_i          packed destination/data, requester n at slice n
//   wreg_{a,b}_{wr,addr,data}_o    registered register-file write ports
//   issue_i/issue_addr_i           decode marks a destination register pending
//   rreg_{a,b}_{rd,addr}_i         decode read operands
//   hazard_{a,b}_o                 operand not yet architecturally visible
//
// Build option: define MERLIN_WB_ARB_RR_EN for round-robin priority; otherwise
// priority is fixed with requester 0 highest.
module merlin_wb_arbiter #(
   parameter int C_NREQ  = 3,
   parameter int RV_XLEN = 32
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [C_NREQ-1:0]         req_valid_i,
   output logic [C_NREQ-1:0]         req_ready_o,
   input  logic [5*C_NREQ-1:0]       req_addr_i,
   input  logic [RV_XLEN*C_NREQ-1:0] req_data_i,
   output logic                      wreg_a_wr_o,
   output logic                      wreg_b_wr_o,
   output logic [4:0]                wreg_a_addr_o,
   output logic [4:0]                wreg_b_addr_o,
   output logic [RV_XLEN-1:0]        wreg_a_data_o,
   output logic [RV_XLEN-1:0]        wreg_b_data_o,
   input  logic                      issue_i,
   input  logic [4:0]                issue_addr_i,
   input  logic                      rreg_a_rd_i,
   input  logic                      rreg_b_rd_i,
   input  logic [4:0]                rreg_a_addr_i,
   input  logic [4:0]                rreg_b_addr_i,
   output logic                      hazard_a_o,
   output logic                      hazard_b_o
);

   localparam int PW = (C_NREQ > 1) ? $clog2(C_NREQ) : 1;

   // Scan starts just after ptr; in fixed mode ptr is the last index so the
   // scan always begins at requester 0.
   logic [PW-1:0] ptr;
`ifdef MERLIN_WB_ARB_RR_EN
   logic [PW-1:0] ptr_q, ptr_d;
   assign ptr = ptr_q;
`else
   assign ptr = PW'(C_NREQ - 1);
`endif

   logic               a_vld_d, b_vld_d;
   logic [4:0]         a_addr_d, b_addr_d;
   logic [RV_XLEN-1:0] a_data_d, b_data_d;
   logic [C_NREQ-1:0]  ready_d;

   logic               wa_q, wb_q;
   logic [4:0]         wa_addr_q, wb_addr_q;
   logic [RV_XLEN-1:0] wa_data_q, wb_data_q;
   logic [31:1]        pend_q, pend_d;

   // Two passes over the requesters emulate a rotated scan: pass 0 covers
   // indices above ptr, pass 1 wraps around to indices up to ptr.
   always_comb begin
      a_vld_d  = 1'b0;
      b_vld_d  = 1'b0;
      a_addr_d = '0;
      b_addr_d = '0;
      a_data_d = '0;
      b_data_d = '0;
      ready_d  = '0;
`ifdef MERLIN_WB_ARB_RR_EN
      ptr_d    = ptr_q;
`endif
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < C_NREQ; i++) begin
            if (((pass == 0) && (PW'(i) > ptr)) || ((pass == 1) && (PW'(i) <= ptr))) begin
               if (req_valid_i[i]) begin
                  if (req_addr_i[5*i +: 5] == 5'd0) begin
                     // x0 writes are discarded: accept without using a port
                     ready_d[i] = 1'b1;
                  end else if (!a_vld_d) begin
                     a_vld_d    = 1'b1;
                     a_addr_d   = req_addr_i[5*i +: 5];
                     a_data_d   = req_data_i[RV_XLEN*i +: RV_XLEN];
                     ready_d[i] = 1'b1;
`ifdef MERLIN_WB_ARB_RR_EN
                     ptr_d      = PW'(i);
`endif
                  end else if (!b_vld_d && (req_addr_i[5*i +: 5] != a_addr_d)) begin
                     // same-address requests never share a cycle; loser retries
                     b_vld_d    = 1'b1;
                     b_addr_d   = req_addr_i[5*i +: 5];
                     b_data_d   = req_data_i[RV_XLEN*i +: RV_XLEN];
                     ready_d[i] = 1'b1;
`ifdef MERLIN_WB_ARB_RR_EN
                     ptr_d      = PW'(i);
`endif
                  end
               end
            end
         end
      end
   end

   assign req_ready_o = reset_i ? ready_d : '0;

   // Issue is applied after the clears so a same-cycle issue (younger
   // instruction) keeps the register pending.
   always_comb begin
      pend_d = pend_q;
      if (a_vld_d) pend_d[a_addr_d] = 1'b0;
      if (b_vld_d) pend_d[b_addr_d] = 1'b0;
      if (issue_i && (issue_addr_i != 5'd0)) pend_d[issue_addr_i] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wa_q      <= 1'b0;
         wb_q      <= 1'b0;
         wa_addr_q <= '0;
         wb_addr_q <= '0;
         wa_data_q <= '0;
         wb_data_q <= '0;
         pend_q    <= '0;
`ifdef MERLIN_WB_ARB_RR_EN
         ptr_q     <= PW'(C_NREQ - 1);
`endif
      end else begin
         wa_q   <= a_vld_d;
         wb_q   <= b_vld_d;
         pend_q <= pend_d;
         if (a_vld_d) begin
            wa_addr_q <= a_addr_d;
            wa_data_q <= a_data_d;
         end
         if (b_vld_d) begin
            wb_addr_q <= b_addr_d;
            wb_data_q <= b_data_d;
         end
`ifdef MERLIN_WB_ARB_RR_EN
         ptr_q <= ptr_d;
`endif
      end
   end

   assign wreg_a_wr_o   = wa_q;
   assign wreg_b_wr_o   = wb_q;
   assign wreg_a_addr_o = wa_addr_q;
   assign wreg_b_addr_o = wb_addr_q;
   assign wreg_a_data_o = wa_data_q;
   assign wreg_b_data_o = wb_data_q;

   // A register stays hazardous while pending and while its write sits in the
   // output stage; it becomes readable the cycle after the strobe.
   assign hazard_a_o = rreg_a_rd_i && (rreg_a_addr_i != 5'd0) &&
                       (pend_q[rreg_a_addr_i] ||
                        (wa_q && (wa_addr_q == rreg_a_addr_i)) ||
                        (wb_q && (wb_addr_q == rreg_a_addr_i)));
   assign hazard_b_o = rreg_b_rd_i && (rreg_b_addr_i != 5'd0) &&
                       (pend_q[rreg_b_addr_i] ||
                        (wa_q && (wa_addr_q == rreg_b_addr_i)) ||
                        (wb_q && (wb_addr_q == rreg_b_addr_i)));

endmodule

// File: tb/tb_merlin_wb_arbiter.sv
module tb_merlin_wb_arbiter;
   localparam int N  = 3;
   localparam int XL = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [N-1:0]  valid, ready;
   logic [5*N-1:0] addr;
   logic [XL*N-1:0] data;
   logic          wa_wr, wb_wr;
   logic [4:0]    wa_addr, wb_addr;
   logic [XL-1:0] wa_data, wb_data;
   logic          issue;
   logic [4:0]    issue_addr;
   logic          ra_rd, rb_rd;
   logic [4:0]    ra_addr, rb_addr;
   logic          haz_a, haz_b;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit          mpend [32];
   logic        m_wa, m_wb;
   logic [4:0]  m_wa_addr, m_wb_addr;
   logic [31:0] m_wa_data, m_wb_data;
   int          mptr;

   merlin_wb_arbiter #(.C_NREQ(N), .RV_XLEN(XL)) dut (
      .clk_i(clk), .reset_i(rst_n),
      .req_valid_i(valid), .req_ready_o(ready), .req_addr_i(addr), .req_data_i(data),
      .wreg_a_wr_o(wa_wr), .wreg_b_wr_o(wb_wr),
      .wreg_a_addr_o(wa_addr), .wreg_b_addr_o(wb_addr),
      .wreg_a_data_o(wa_data), .wreg_b_data_o(wb_data),
      .issue_i(issue), .issue_addr_i(issue_addr),
      .rreg_a_rd_i(ra_rd), .rreg_b_rd_i(rb_rd),
      .rreg_a_addr_i(ra_addr), .rreg_b_addr_i(rb_addr),
      .hazard_a_o(haz_a), .hazard_b_o(haz_b));

   function automatic void model_reset();
      foreach (mpend[k]) mpend[k] = 1'b0;
      m_wa = 1'b0; m_wb = 1'b0;
      m_wa_addr = '0; m_wb_addr = '0;
      m_wa_data = '0; m_wb_data = '0;
      mptr = N - 1;
   endfunction

   // Grant rule: visit requesters starting after ptr; x0 accepted for free,
   // first nonzero -> A, next nonzero with a different address -> B.
   function automatic void mgrant(input logic [N-1:0] v, input logic [5*N-1:0] a,
                                  input int ptr, output logic [N-1:0] rdy,
                                  output int ia, output int ib);
      rdy = '0; ia = -1; ib = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         logic [4:0] ad;
         idx = (ptr + 1 + k) % N;
         ad = a[5*idx +: 5];
         if (v[idx]) begin
            if (ad == 5'd0) rdy[idx] = 1'b1;
            else if (ia < 0) begin ia = idx; rdy[idx] = 1'b1; end
            else if (ib < 0 && ad != a[5*ia +: 5]) begin ib = idx; rdy[idx] = 1'b1; end
         end
      end
   endfunction

   function automatic logic mhaz(input logic rd, input logic [4:0] a);
      return rd && (a != 5'd0) &&
             (mpend[a] || (m_wa && m_wa_addr == a) || (m_wb && m_wb_addr == a));
   endfunction

   task automatic set_req(input int r, input logic v, input logic [4:0] a, input logic [31:0] d);
      valid[r] = v;
      addr[5*r +: 5] = a;
      data[XL*r +: XL] = d;
   endtask

   task automatic clear_inputs();
      valid = '0; addr = '0; data = '0;
      issue = 1'b0; issue_addr = '0;
      ra_rd = 1'b0; rb_rd = 1'b0; ra_addr = '0; rb_addr = '0;
   endtask

   // ends at posedge+1 with reset released
   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      set_req(0, 1'b1, 5'd1, 32'h11); set_req(1, 1'b1, 5'd2, 32'h22); set_req(2, 1'b1, 5'd3, 32'h33);
      ra_rd = 1'b1; ra_addr = 5'd5;
      repeat (2) @(posedge clk);
      #3;
      checks++; if (ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", ready); end
      checks++; if (wa_wr !== 1'b0 || wb_wr !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", wa_wr, wb_wr); end
      checks++; if (wa_addr !== 5'd0 || wb_addr !== 5'd0 || wa_data !== 32'd0 || wb_data !== 32'd0) begin
         failures++; $display("FAIL reset_addr_data got=%0d/%0d/%h/%h exp=0", wa_addr, wb_addr, wa_data, wb_data); end
      checks++; if (haz_a !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", haz_a); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_inputs();
      model_reset();
   endtask

   task automatic test_single();
      do_reset();
      set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      #4;
      checks++; if (ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", ready); end
      @(posedge clk); #1;
      valid = '0;
      checks++; if (wa_wr !== 1'b1 || wa_addr !== 5'd5 || wa_data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL single_portA got=%b/%0d/%h exp=1/5/deadbeef", wa_wr, wa_addr, wa_data); end
      checks++; if (wb_wr !== 1'b0) begin failures++; $display("FAIL single_portB got=%b exp=0", wb_wr); end
      @(posedge clk); #1;
      checks++; if (wa_wr !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", wa_wr); end
   endtask

   task automatic test_three();
      do_reset();
      set_req(0, 1'b1, 5'd1, 32'hA1); set_req(1, 1'b1, 5'd2, 32'hB2); set_req(2, 1'b1, 5'd3, 32'hC3);
      #4;
      checks++; if (ready !== 3'b011) begin failures++; $display("FAIL three_ready1 got=%b exp=011", ready); end
      @(posedge clk); #1;
      valid[0] = 1'b0; valid[1] = 1'b0;
      checks++; if (wa_wr !== 1'b1 || wa_addr !== 5'd1 || wa_data !== 32'hA1 || wb_wr !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 32'hB2) begin
         failures++; $display("FAIL three_ports1 got=%b/%0d/%h %b/%0d/%h exp=1/1/a1 1/2/b2", wa_wr, wa_addr, wa_data, wb_wr, wb_addr, wb_data); end
      #3;
      checks++; if (ready !== 3'b100) begin failures++; $display("FAIL three_ready2 got=%b exp=100", ready); end
      @(posedge clk); #1;
      valid = '0;
      checks++; if (wa_wr !== 1'b1 || wa_addr !== 5'd3 || wa_data !== 32'hC3 || wb_wr !== 1'b0) begin
         failures++; $display("FAIL three_ports2 got=%b/%0d/%h wb=%b exp=1/3/c3 wb=0", wa_wr, wa_addr, wa_data, wb_wr); end
`ifdef MERLIN_WB_ARB_RR_EN
      begin
         int cnt [N];
         do_reset();
         foreach (cnt[k]) cnt[k] = 0;
         set_req(0, 1'b1, 5'd1, 32'h1); set_req(1, 1'b1, 5'd2, 32'h2); set_req(2, 1'b1, 5'd3, 32'h3);
         repeat (3) begin
            #4;
            for (int k = 0; k < N; k++) if (ready[k]) cnt[k]++;
            @(posedge clk); #1;
         end
         valid = '0;
         for (int k = 0; k < N; k++) begin
            checks++; if (cnt[k] != 2) begin failures++; $display("FAIL rr_fairness req%0d got=%0d exp=2", k, cnt[k]); end
         end
      end
`endif
   endtask

   task automatic test_collision();
      do_reset();
      set_req(0, 1'b1, 5'd7, 32'h70); set_req(1, 1'b1, 5'd7, 32'h71);
      #4;
      checks++; if (ready !== 3'b001) begin failures++; $display("FAIL coll_ready1 got=%b exp=001", ready); end
      @(posedge clk); #1;
      valid[0] = 1'b0;
      checks++; if (wa_wr !== 1'b1 || wa_addr !== 5'd7 || wa_data !== 32'h70 || wb_wr !== 1'b0) begin
         failures++; $display("FAIL coll_ports1 got=%b/%0d/%h wb=%b exp=1/7/70 wb=0", wa_wr, wa_addr, wa_data, wb_wr); end
      #3;
      checks++; if (ready !== 3'b010) begin failures++; $display("FAIL coll_ready2 got=%b exp=010", ready); end
      @(posedge clk); #1;
      valid = '0;
      checks++; if (wa_wr !== 1'b1 || wa_addr !== 5'd7 || wa_data !== 32'h71 || wb_wr !== 1'b0) begin
         failures++; $display("FAIL coll_ports2 got=%b/%0d/%h wb=%b exp=1/7/71 wb=0", wa_wr, wa_addr, wa_data, wb_wr); end
   endtask

   task automatic test_x0();
      do_reset();
      set_req(0, 1'b1, 5'd4, 32'h44); set_req(1, 1'b1, 5'd0, 32'h99);
      #4;
      checks++; if (ready !== 3'b011) begin failures++; $display("FAIL x0_ready got=%b exp=011", ready); end
      @(posedge clk); #1;
      valid = '0;
      checks++; if (wa_wr !== 1'b1 || wa_addr !== 5'd4 || wa_data !== 32'h44 || wb_wr !== 1'b0) begin
         failures++; $display("FAIL x0_ports got=%b/%0d/%h wb=%b exp=1/4/44 wb=0", wa_wr, wa_addr, wa_data, wb_wr); end
   endtask

   task automatic test_scoreboard();
      do_reset();
      issue = 1'b1; issue_addr = 5'd9;
      @(posedge clk); #1;
      issue = 1'b0;
      ra_rd = 1'b1; ra_addr = 5'd9; rb_rd = 1'b0; rb_addr = 5'd9;
      set_req(0, 1'b1, 5'd9, 32'h900D);
      #3;
      checks++; if (haz_a !== 1'b1) begin failures++; $display("FAIL sb_haz_N got=%b exp=1", haz_a); end
      checks++; if (haz_b !== 1'b0) begin failures++; $display("FAIL sb_haz_b_disabled got=%b exp=0", haz_b); end
      @(posedge clk); #1;
      valid = '0;
      #2;
      checks++; if (haz_a !== 1'b1) begin failures++; $display("FAIL sb_haz_N1 got=%b exp=1", haz_a); end
      @(posedge clk); #1;
      issue = 1'b1; issue_addr = 5'd9;
      #2;
      checks++; if (haz_a !== 1'b0) begin failures++; $display("FAIL sb_haz_N2 got=%b exp=0", haz_a); end
      @(posedge clk); #1;
      set_req(0, 1'b1, 5'd9, 32'h900E);
      #3;
      checks++; if (ready !== 3'b001) begin failures++; $display("FAIL sb_same_ready got=%b exp=001", ready); end
      @(posedge clk); #1;
      issue = 1'b0; valid = '0;
      @(posedge clk); #1;
      checks++; if (wa_wr !== 1'b0 || haz_a !== 1'b1) begin
         failures++; $display("FAIL sb_set_wins got wr=%b haz=%b exp wr=0 haz=1", wa_wr, haz_a); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int a = 1; a <= 4; a++) begin
         issue = 1'b1; issue_addr = 5'(a);
         @(posedge clk); #1;
      end
      issue = 1'b0;
      ra_rd = 1'b1; ra_addr = 5'd3;
      set_req(0, 1'b1, 5'd10, 32'hABCD);
      #2;
      checks++; if (haz_a !== 1'b1) begin failures++; $display("FAIL rm_pending_before got=%b exp=1", haz_a); end
      @(posedge clk); #1;
      set_req(0, 1'b1, 5'd11, 32'h1111);
      checks++; if (wa_wr !== 1'b1) begin failures++; $display("FAIL rm_loaded got=%b exp=1", wa_wr); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (wa_wr !== 1'b0 || wb_wr !== 1'b0 || wa_addr !== 5'd0 || wa_data !== 32'd0) begin
         failures++; $display("FAIL rm_stage_cleared got=%b%b/%0d/%h exp=00/0/0", wa_wr, wb_wr, wa_addr, wa_data); end
      checks++; if (ready !== 3'b000) begin failures++; $display("FAIL rm_ready got=%b exp=000", ready); end
      for (int a = 1; a <= 4; a++) begin
         ra_addr = 5'(a);
         #1;
         checks++; if (haz_a !== 1'b0) begin failures++; $display("FAIL rm_pending_x%0d got=%b exp=0", a, haz_a); end
      end
      @(posedge clk); #1;
      valid = '0;
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         checks++; if (wa_wr !== 1'b0 || wb_wr !== 1'b0) begin
            failures++; $display("FAIL rm_no_write got=%b%b exp=00", wa_wr, wb_wr); end
      end
      clear_inputs();
      model_reset();
   endtask

   task automatic test_random();
      bit          have [N];
      logic [4:0]  ta [N];
      logic [31:0] td [N];
      logic [N-1:0] er;
      int ia, ib;
      do_reset();
      foreach (have[k]) have[k] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int r = 0; r < N; r++) begin
            if (!have[r] && $urandom_range(0, 2) != 0) begin
               have[r] = 1'b1;
               ta[r] = 5'($urandom_range(0, 7));
               td[r] = $urandom;
            end
            set_req(r, have[r], have[r] ? ta[r] : 5'($urandom_range(0, 31)), have[r] ? td[r] : $urandom);
         end
         issue = ($urandom_range(0, 3) == 0);
         issue_addr = 5'($urandom_range(0, 7));
         ra_rd = 1'($urandom_range(0, 1)); ra_addr = 5'($urandom_range(0, 7));
         rb_rd = 1'($urandom_range(0, 1)); rb_addr = 5'($urandom_range(0, 7));
         #4;
         mgrant(valid, addr, mptr, er, ia, ib);
         checks++; if (ready !== er) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ready, er); end
         checks++; if (haz_a !== mhaz(ra_rd, ra_addr) || haz_b !== mhaz(rb_rd, rb_addr)) begin
            failures++; $display("FAIL rnd_hazard cyc=%0d got=%b%b exp=%b%b", cyc, haz_a, haz_b, mhaz(ra_rd, ra_addr), mhaz(rb_rd, rb_addr)); end
         @(posedge clk);
         m_wa = (ia >= 0);
         m_wb = (ib >= 0);
         if (ia >= 0) begin m_wa_addr = ta[ia]; m_wa_data = td[ia]; mpend[ta[ia]] = 1'b0; end
         if (ib >= 0) begin m_wb_addr = ta[ib]; m_wb_data = td[ib]; mpend[ta[ib]] = 1'b0; end
         if (issue && issue_addr != 5'd0) mpend[issue_addr] = 1'b1;
`ifdef MERLIN_WB_ARB_RR_EN
         if (ib >= 0) mptr = ib;
         else if (ia >= 0) mptr = ia;
`endif
         for (int r = 0; r < N; r++) if (er[r]) have[r] = 1'b0;
         #1;
         checks++; if (wa_wr !== m_wa || wa_addr !== m_wa_addr || wa_data !== m_wa_data) begin
            failures++; $display("FAIL rnd_portA cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, wa_wr, wa_addr, wa_data, m_wa, m_wa_addr, m_wa_data); end
         checks++; if (wb_wr !== m_wb || wb_addr !== m_wb_addr || wb_data !== m_wb_data) begin
            failures++; $display("FAIL rnd_portB cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, wb_wr, wb_addr, wb_data, m_wb, m_wb_addr, m_wb_data); end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_three();
      test_collision();
      test_x0();
      test_scoreboard();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/merlin_wb_arbiter.md
# merlin_wb_arbiter

Writeback arbiter and register scoreboard for the integer register file. Collects destination-register writes from up to `C_NREQ` execution sources (ALU, load unit, CSR/multiply) over valid/ready handshakes, grants at most two per cycle and drives them onto the register file's two write ports through a registered stage. Tracks pending destination registers so decode can detect read-after-write hazards on its two read addresses.

## Interface
- `C_NREQ`, 3, number of writeback requesters (2..8); index 0 = ALU.
- `clk_i` in 1: clock, all state on rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `req_valid_i` in C_NREQ: per-requester write request.
- `req_ready_o` out C_NREQ: per-requester grant; transfer when valid & ready.
- `req_addr_i` in 5*C_NREQ: destination register, requester n at [5n+4:5n].
- `req_data_i` in RV_XLEN*C_NREQ: write data, requester n at [XLEN*n+XLEN-1:XLEN*n].
- `wreg_a_wr_o`, `wreg_b_wr_o` out 1: register-file write strobes.
- `wreg_a_addr_o`, `wreg_b_addr_o` out 5: write addresses.
- `wreg_a_data_o`, `wreg_b_data_o` out RV_XLEN: write data.
- `issue_i` in 1: decode issues an instruction with destination `issue_addr_i`.
- `issue_addr_i` in 5: destination of issuing instruction.
- `rreg_a_rd_i`, `rreg_b_rd_i` in 1: decode read enables.
- `rreg_a_addr_i`, `rreg_b_addr_i` in 5: decode read addresses.
- `hazard_a_o`, `hazard_b_o` out 1: read operand not yet architecturally visible.

## Operation
- Grant: scan requesters in priority order; first valid -> port A, second valid with address different from A's -> port B. Others see ready=0 and must hold valid/addr/data stable.
- Address x0 requests: ready=1 whenever valid, consume no port, produce no write strobe.
- Same-address collision: second requester to an address already granted this cycle is not granted; retries next cycle.
- Output stage: accepted requests registered into port A/B strobe/addr/data; strobes low in cycles with no grant; addr/data hold last value.
- Scoreboard: 31-bit `pending` (x1..x31). `issue_i` with nonzero address sets bit; accepted nonzero writeback clears bit. Same-cycle set and clear of one address: set wins (issue is the younger instruction).
- Issue to an already-pending register is illegal for upstream; bit stays set, first writeback clears it.
- Hazard: `hazard_x_o = rreg_x_rd_i & addr!=0 & (pending[addr] | (wreg_a_wr_o & wreg_a_addr_o==addr) | (wreg_b_wr_o & wreg_b_addr_o==addr))`; combinational. No bypass of current-cycle grants.

## Timing
- Reset (reset_i low, immediate): strobes 0, addr/data 0, pending all 0, RR pointer = C_NREQ-1 (requester 0 highest first); `req_ready_o` forced 0; hazards follow formula (0 unless read of nothing pending -> 0).
- `req_ready_o` combinational from `req_valid_i`/`req_addr_i` and state; no dependence on ready back-pressure from the register file (always accepts).
- Latency: handshake in cycle N -> write strobe in cycle N+1 -> data readable from register file in cycle N+2. Hazard held through N+1 via output-stage match; clears in N+2.
- Throughput: 2 nonzero writes per cycle sustained.
- Reset mid-operation: in-flight output stage discarded, no write issued; pending cleared.

## Configuration
- `MERLIN_WB_ARB_RR_EN` defined: round-robin; priority starts at pointer+1 (mod C_NREQ); pointer updates to highest-index-in-scan-order requester granted a port this cycle; unchanged if no port grant.
- Undefined: fixed priority, index 0 highest; pointer logic absent.

## Test plan
- Single request: req0 valid addr=5 data=0xDEADBEEF -> ready0=1 same cycle; next cycle wreg_a_wr_o=1, addr 5, data 0xDEADBEEF; wreg_b_wr_o=0.
- Three valid, addrs 1,2,3 -> two granted cycle 1 (fixed: req0->A, req1->B), req2 next cycle; with RR_EN, over 3 cycles of continuous valid each requester granted twice.
- Collision: req0 and req1 both addr 7 -> only req0 granted; req1 granted following cycle on port A; no cycle has A and B both addr 7.
- x0: req1 valid addr 0 with req0 addr 4 -> both ready; only one write strobe (addr 4).
- Scoreboard: issue addr 9, read addr 9 -> hazard 1; writeback accepted cycle N -> hazard 1 in N, N+1, 0 in N+2; issue and writeback of 9 same cycle -> pending stays 1.
- Reset asserted with output stage loaded and pending=0x1E -> strobes 0 and pending 0 immediately, no write after release.
